div_unit: RTL

Multi-cycle RV32M divide/remainder unit in the EX stage. It accepts operands from the operand-select muxes, iterates one quotient bit per cycle with radix-2 restoring division, and presents the result to the writeback-select mux. The hazard unit stalls the pipeline while `busy` is high.

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_unit_if.sv | 27 ++
 rtl/div_core.sv | 62 ++++++
 rtl/div_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and encodings for the RV32M divide/remainder unit.
package div_pkg;

    typedef enum logic [1:0] {
        OpDiv  = 2'd0,
        OpDivu = 2'd1,
        OpRem  = 2'd2,
        OpRemu = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_t;

    // op[0] set means unsigned, op[1] set means remainder (funct3[1:0])
    localparam int unsigned OpUnsignedBit = 0;
    localparam int unsigned OpRemBit      = 1;

    function automatic logic op_is_signed(input div_op_t op);
        return !op[OpUnsignedBit];
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return op[OpRemBit];
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Operand/result handshake between the EX operand muxes and the divide unit.
interface div_unit_if
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    div_op_t               op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  flush;
    logic                  busy;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output in_valid, op, dividend, divisor, flush,
        input  in_ready, busy, out_valid, result
    );

    modport slave (
        input  in_valid, op, dividend, divisor, flush,
        output in_ready, busy, out_valid, result
    );

endinterface

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, DATA_WIDTH cycles per start.
module div_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_last,
    output logic [DATA_WIDTH-1:0] o_quo,
    output logic [DATA_WIDTH-1:0] o_rem
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [CntW-1:0]       r_cnt;
    logic                  r_run;

    // One extra bit so the shifted partial remainder never loses its carry
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_sub;
    logic                  w_ge;

    assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_sub   = w_shift - {1'b0, r_dvs};
    assign w_ge    = w_shift >= {1'b0, r_dvs};
    assign o_last  = r_run && (r_cnt == '0);
    assign o_quo   = r_quo;
    assign o_rem   = r_rem;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_abort) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= CntW'(DATA_WIDTH - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_rem <= w_ge ? w_sub[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
            r_quo <= {r_quo[DATA_WIDTH-2:0], w_ge};
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU wrapper: sign handling, special cases, handshake and flush.
// Optional DIV_EARLY_EXIT_EN resolves |dividend| < |divisor| at accept.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rstn,
    div_unit_if.slave  bus
);
    div_state_t            r_state;
    logic                  r_busy;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_is_rem;
    logic                  r_quo_neg;
    logic                  r_rem_neg;

    logic                  w_accept;
    logic                  w_signed;
    logic                  w_is_rem;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic                  w_early;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_spec_result;
    logic [DATA_WIDTH-1:0] w_fix_result;
    logic                  w_core_last;
    logic [DATA_WIDTH-1:0] w_core_quo;
    logic [DATA_WIDTH-1:0] w_core_rem;

    assign w_accept = bus.in_valid && !r_busy && !bus.flush;
    assign w_signed = op_is_signed(bus.op);
    assign w_is_rem = op_is_rem(bus.op);
    assign w_neg_a  = w_signed && bus.dividend[DATA_WIDTH-1];
    assign w_neg_b  = w_signed && bus.divisor[DATA_WIDTH-1];
    assign w_mag_a  = w_neg_a ? -bus.dividend : bus.dividend;
    assign w_mag_b  = w_neg_b ? -bus.divisor : bus.divisor;

    assign w_div_zero = (bus.divisor == '0);
    assign w_ovf      = w_signed && (bus.dividend == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                        && (bus.divisor == '1);
`ifdef DIV_EARLY_EXIT_EN
    assign w_early    = !w_div_zero && (w_mag_a < w_mag_b);
`else
    assign w_early    = 1'b0;
`endif
    assign w_special  = w_div_zero || w_ovf || w_early;

    always_comb begin
        w_spec_result = '0;
        if (w_div_zero) begin
            w_spec_result = w_is_rem ? bus.dividend : '1;
        end else if (w_ovf) begin
            w_spec_result = w_is_rem ? '0 : bus.dividend;
        end else begin
            w_spec_result = w_is_rem ? bus.dividend : '0;
        end
    end

    assign w_fix_result = r_is_rem ? (r_rem_neg ? -w_core_rem : w_core_rem)
                                   : (r_quo_neg ? -w_core_quo : w_core_quo);

    div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk        (clk),
        .rstn       (rstn),
        .i_start    (w_accept && !w_special),
        .i_abort    (bus.flush),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_last     (w_core_last),
        .o_quo      (w_core_quo),
        .o_rem      (w_core_rem)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_is_rem    <= 1'b0;
            r_quo_neg   <= 1'b0;
            r_rem_neg   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.flush) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    // DONE accepts like IDLE so back-to-back ops need no bubble
                    StIdle, StDone: begin
                        r_state <= StIdle;
                        if (w_accept) begin
                            if (w_special) begin
                                r_result    <= w_spec_result;
                                r_out_valid <= 1'b1;
                                r_state     <= StDone;
                            end else begin
                                r_is_rem  <= w_is_rem;
                                r_quo_neg <= w_neg_a ^ w_neg_b;
                                r_rem_neg <= w_neg_a;
                                r_busy    <= 1'b1;
                                r_state   <= StCalc;
                            end
                        end
                    end
                    StCalc: begin
                        if (w_core_last) begin
                            r_state <= StFix;
                        end
                    end
                    StFix: begin
                        r_result    <= w_fix_result;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StDone;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = !r_busy;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

endmodule
